uart_tx_regctl: RTL and testbench

Register-mapped UART transmit controller: owns the four peripheral registers (status, interrupt mask, data, baud-rate divisor) selected by chip-select and a 2-bit address, and sequences serial transmission of each byte written to the data register. Sits behind the peripheral bus decode on the CPU side and drives the serial line and one interrupt line.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baudgen.sv | 30 +++
 rtl/uart_tx_regctl.sv | 126 ++++++++++++
 tb/tb_uart_tx_regctl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit controller.
package uart_pkg;

    // Register map
    localparam logic [1:0] ADDR_STATUS  = 2'b00;
    localparam logic [1:0] ADDR_INTMASK = 2'b01;
    localparam logic [1:0] ADDR_DATA    = 2'b10;
    localparam logic [1:0] ADDR_BAUD    = 2'b11;

    // Status register bit positions
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_t;

endpackage

// File: rtl/uart_baudgen.sv
// Loadable baud down-counter. The divisor is re-sampled at every bit
// boundary, so a divisor change mid-frame applies from the next bit.
module uart_baudgen #(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    input  logic            en,
    input  logic [DIVW-1:0] divisor,
    output logic            tick
);

    logic [DIVW-1:0] cnt;

    // Count down from divisor to 0, reloading on restart or on reaching 0
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= divisor;
        end else if (en) begin
            if (cnt == '0) cnt <= divisor;
            else           cnt <= cnt - DIVW'(1);
        end
    end

    assign tick = en && !restart && (cnt == '0);

endmodule

// File: rtl/uart_tx_regctl.sv
// Register-mapped UART transmitter: status/intmask/data/divisor registers
// and a START/DATA/STOP frame sequencer driving txd.
module uart_tx_regctl
    import uart_pkg::*;
#(
    parameter int DIVW = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       txd,
    output logic       irq
);

    tx_state_t       state, state_nxt;
    logic [2:0]      bit_idx;
    logic [7:0]      data_reg;
    logic [DIVW-1:0] divisor;
    logic [2:1]      intmask;
    logic            done, ovr, busy;
    logic            tick;

    logic wr_en, rd_en, data_wr, stat_wr, accept, frame_end;

    assign wr_en     = CS && we;
    assign rd_en     = CS && !we;
    assign data_wr   = wr_en && (addr == ADDR_DATA);
    assign stat_wr   = wr_en && (addr == ADDR_STATUS);
    // busy comes straight from the state, so a write on the edge that ends
    // the stop bit still sees busy=1 and is rejected
    assign accept    = data_wr && !busy;
    assign frame_end = (state == STOP) && tick;

    uart_baudgen #(.DIVW(DIVW)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .en      (busy),
        .divisor (divisor),
        .tick    (tick)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: serial line level and busy flag
    always_comb begin
        txd  = 1'b1;
        busy = 1'b1;
        case (state)
            IDLE:  busy = 1'b0;
            START: txd  = 1'b0;
            DATA:  txd  = data_reg[bit_idx];
            STOP:  txd  = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Data bit index, wraps 7->0 as the frame leaves DATA
    always_ff @(posedge clk) begin
        if (reset)                      bit_idx <= '0;
        else if (accept)                bit_idx <= '0;
        else if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
    end

    // Sticky status bits; a set on the same edge as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (frame_end)                    done <= 1'b1;
            else if (stat_wr && wdata[ST_DONE]) done <= 1'b0;
            if (data_wr && busy)              ovr  <= 1'b1;
            else if (stat_wr && wdata[ST_OVR])  ovr  <= 1'b0;
        end
    end

    // Plain RW registers and the last accepted data byte
    always_ff @(posedge clk) begin
        if (reset) begin
            intmask  <= '0;
            divisor  <= '0;
            data_reg <= '0;
        end else begin
            if (wr_en && addr == ADDR_INTMASK) intmask <= wdata[2:1];
            if (wr_en && addr == ADDR_BAUD)    divisor <= wdata[DIVW-1:0];
            if (accept)                        data_reg <= wdata;
        end
    end

    // Combinational read mux; zero when not reading
    always_comb begin
        rdata = 8'h00;
        if (rd_en) begin
            case (addr)
                ADDR_STATUS:  rdata = {5'b0, ovr, done, busy};
                ADDR_INTMASK: rdata = {5'b0, intmask, 1'b0};
                ADDR_DATA:    rdata = data_reg;
                default:      rdata[DIVW-1:0] = divisor;
            endcase
        end
    end

    assign irq = (done && intmask[1]) || (ovr && intmask[2]);

endmodule

// File: tb/tb_uart_tx_regctl.sv
// Scoreboard bench for uart_tx_regctl: expected txd levels are queued per
// cycle when a byte is accepted and popped as the line is observed.
module tb_uart_tx_regctl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CS = 1'b0;
    logic [1:0] addr = 2'b00;
    logic       we = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       txd, irq;

    int tests = 0;
    int fails = 0;
    int cur_div = 0;
    bit exp_q[$];

    uart_tx_regctl #(.DIVW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .CS    (CS),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .txd   (txd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Write takes effect on the next rising edge; returns 1ns after it
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        CS = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        CS = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        CS = 1'b1; we = 1'b0; addr = a;
        #1;
        v = rdata;
        CS = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        bit b;
        for (int k = 0; k < 10; k++) begin
            b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
            for (int c = 0; c <= cur_div; c++) exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [7:0] d);
        wr(ADDR_DATA, d);
        push_frame(d);
    endtask

    task automatic set_div(input logic [7:0] d);
        wr(ADDR_BAUD, d);
        cur_div = d;
    endtask

    // Pops one expected txd level per cycle; optionally writes data at cycle inj_at
    task automatic run_frame(input int inj_at, input logic [7:0] inj_d);
        int i = 0;
        bit e;
        logic [7:0] st;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (txd !== e) begin
                fails++;
                $display("FAIL txd cycle %0d: got %b expected %b", i, txd, e);
            end
            rd(ADDR_STATUS, st);
            tests++;
            if (st[ST_BUSY] !== 1'b1) begin
                fails++;
                $display("FAIL busy cycle %0d: got %b expected 1", i, st[ST_BUSY]);
            end
            if (i == inj_at) wr(ADDR_DATA, inj_d);
            else             step();
            i++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        step(); step();
        @(negedge clk); reset = 1'b0;
        step();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk($sformatf("reset_rd%0d", a), v, 8'h00);
        end
        chk("reset_txd", {7'b0, txd}, 8'h01);
        chk("reset_irq", {7'b0, irq}, 8'h00);
    endtask

    task automatic test_frame();
        logic [7:0] v;
        set_div(8'd3);
        send(8'hA5);
        run_frame(-1, 8'h00);
        rd(ADDR_STATUS, v);
        chk("frame_status", v, 8'h02);
        rd(ADDR_DATA, v);
        chk("frame_data_rb", v, 8'hA5);
        chk("frame_txd_idle", {7'b0, txd}, 8'h01);
    endtask

    task automatic test_irq_done();
        logic [7:0] v;
        wr(ADDR_STATUS, 8'h02);
        wr(ADDR_INTMASK, 8'h02);
        rd(ADDR_INTMASK, v);
        chk("intmask_rb", v, 8'h02);
        set_div(8'd0);
        send(8'h96);
        chk("irq_low_in_frame", {7'b0, irq}, 8'h00);
        run_frame(-1, 8'h00);
        chk("irq_done_set", {7'b0, irq}, 8'h01);
        wr(ADDR_STATUS, 8'h02);
        chk("irq_done_clr", {7'b0, irq}, 8'h00);
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        wr(ADDR_INTMASK, 8'h04);
        set_div(8'd3);
        send(8'h5A);
        run_frame(10, 8'h3C);
        rd(ADDR_STATUS, v);
        chk("ovr_status", v, 8'h06);
        chk("ovr_irq", {7'b0, irq}, 8'h01);
        rd(ADDR_DATA, v);
        chk("ovr_data_kept", v, 8'h5A);
        wr(ADDR_STATUS, 8'h06);
        rd(ADDR_STATUS, v);
        chk("ovr_cleared", v, 8'h00);
        chk("ovr_irq_clr", {7'b0, irq}, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        set_div(8'd0);
        send(8'hF0);
        run_frame(9, 8'hAA);
        rd(ADDR_STATUS, v);
        chk("b2b_rejected", v, 8'h06);
        send(8'h0F);
        chk("b2b_start_txd", {7'b0, txd}, 8'h00);
        run_frame(-1, 8'h00);
        rd(ADDR_DATA, v);
        chk("b2b_data_rb", v, 8'h0F);
        wr(ADDR_STATUS, 8'h06);
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        wr(ADDR_INTMASK, 8'h06);
        set_div(8'd2);
        send(8'hC3);
        for (int k = 0; k < 8; k++) step();
        @(negedge clk); reset = 1'b1;
        step();
        exp_q.delete();
        cur_div = 0;
        chk("rst_mid_txd", {7'b0, txd}, 8'h01);
        chk("rst_mid_irq", {7'b0, irq}, 8'h00);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk($sformatf("rst_mid_rd%0d", a), v, 8'h00);
        end
        @(negedge clk); reset = 1'b0;
        send(8'h81);
        run_frame(-1, 8'h00);
        rd(ADDR_STATUS, v);
        chk("rst_mid_new_frame", v, 8'h02);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_irq_done();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
